// File: rtl/sram_bist.sv
// BIST controller for a 256x10 synchronous single-port SRAM: writes and reads back
// three patterns over every address, then reports done plus a sticky miscompare flag.
module sram_bist #(
  parameter logic [9:0] value_3ff = 10'h3FF,
  parameter logic [9:0] value_00  = 10'h000,
  parameter logic [9:0] value_2aa = 10'h2AA
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic       bist_en,
  input  logic [9:0] rd_data,
  output logic       csn,
  output logic       wen,
  output logic [9:0] wr_data,
  output logic [7:0] wr_addr,
  output logic       b_done,
  output logic       b_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0] state_r,     state_s;
  logic [1:0] pat_idx_r,   pat_idx_s;
  logic       csn_r,       csn_s;
  logic       wen_r,       wen_s;
  logic [9:0] wr_data_r,   wr_data_s;
  logic [7:0] wr_addr_r,   wr_addr_s;
  logic       b_done_r,    b_done_s;
  logic       b_err_r,     b_err_s;
  logic       cmp_valid_r, cmp_valid_s;
  logic [9:0] cmp_exp_r,   cmp_exp_s;
  logic       abort_s;

  function automatic logic [9:0] pattern_of(input logic [1:0] idx);
    case (idx)
      2'd0:    pattern_of = value_3ff;
      2'd1:    pattern_of = value_00;
      2'd2:    pattern_of = value_2aa;
      default: pattern_of = value_3ff;
    endcase
  endfunction

  assign abort_s = !bist_en && ((state_r == ST_WRITE) || (state_r == ST_READ) || (state_r == ST_DRAIN));

  // Next-state and next-output computation; every output is the registered copy of these.
  always_comb begin
    state_s     = state_r;
    pat_idx_s   = pat_idx_r;
    csn_s       = csn_r;
    wen_s       = wen_r;
    wr_data_s   = wr_data_r;
    wr_addr_s   = wr_addr_r;
    b_done_s    = b_done_r;
    cmp_valid_s = 1'b0;
    cmp_exp_s   = cmp_exp_r;
    // The compare scheduled by last cycle's read lands here; an abort discards it.
    if (cmp_valid_r && (rd_data != cmp_exp_r) && !abort_s) begin
      b_err_s = 1'b1;
    end else begin
      b_err_s = b_err_r;
    end

    if (abort_s) begin
      state_s   = ST_IDLE;
      csn_s     = 1'b1;
      wen_s     = 1'b1;
      wr_addr_s = 8'd0;
      wr_data_s = 10'd0;
      b_done_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          b_done_s  = 1'b0;
          pat_idx_s = 2'd0;
          wr_addr_s = 8'd0;
          if (bist_en) begin
            state_s   = ST_WRITE;
            csn_s     = 1'b0;
            wen_s     = 1'b0;
            wr_data_s = pattern_of(2'd0);
            b_err_s   = 1'b0;
          end else begin
            state_s   = ST_IDLE;
            csn_s     = 1'b1;
            wen_s     = 1'b1;
            wr_data_s = 10'd0;
          end
        end
        ST_WRITE: begin
          csn_s     = 1'b0;
          wr_data_s = pattern_of(pat_idx_r);
          wr_addr_s = wr_addr_r + 8'd1;
          if (wr_addr_r == 8'hFF) begin
            state_s = ST_READ;
            wen_s   = 1'b1;
          end else begin
            state_s = ST_WRITE;
            wen_s   = 1'b0;
          end
        end
        ST_READ: begin
          cmp_valid_s = 1'b1;
          cmp_exp_s   = wr_data_r;
          wr_addr_s   = wr_addr_r + 8'd1;
          wen_s       = 1'b1;
          if (wr_addr_r == 8'hFF) begin
            state_s = ST_DRAIN;
            csn_s   = 1'b1;
          end else begin
            state_s = ST_READ;
            csn_s   = 1'b0;
          end
        end
        ST_DRAIN: begin
          wr_addr_s = 8'd0;
          if (pat_idx_r < 2'd2) begin
            state_s   = ST_WRITE;
            pat_idx_s = pat_idx_r + 2'd1;
            csn_s     = 1'b0;
            wen_s     = 1'b0;
            wr_data_s = pattern_of(pat_idx_r + 2'd1);
          end else begin
            state_s  = ST_DONE;
            csn_s    = 1'b1;
            wen_s    = 1'b1;
            b_done_s = 1'b1;
          end
        end
        ST_DONE: begin
          csn_s = 1'b1;
          wen_s = 1'b1;
          if (bist_en) begin
            state_s  = ST_DONE;
            b_done_s = 1'b1;
          end else begin
            state_s   = ST_IDLE;
            b_done_s  = 1'b0;
            wr_addr_s = 8'd0;
            wr_data_s = 10'd0;
          end
        end
        default: begin
          state_s   = ST_IDLE;
          pat_idx_s = 2'd0;
          csn_s     = 1'b1;
          wen_s     = 1'b1;
          wr_addr_s = 8'd0;
          wr_data_s = 10'd0;
          b_done_s  = 1'b0;
        end
      endcase
    end
  end

  // State, compare pipeline and output registers.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_r     <= ST_IDLE;
      pat_idx_r   <= 2'd0;
      csn_r       <= 1'b1;
      wen_r       <= 1'b1;
      wr_data_r   <= 10'd0;
      wr_addr_r   <= 8'd0;
      b_done_r    <= 1'b0;
      b_err_r     <= 1'b0;
      cmp_valid_r <= 1'b0;
      cmp_exp_r   <= 10'd0;
    end else begin
      state_r     <= state_s;
      pat_idx_r   <= pat_idx_s;
      csn_r       <= csn_s;
      wen_r       <= wen_s;
      wr_data_r   <= wr_data_s;
      wr_addr_r   <= wr_addr_s;
      b_done_r    <= b_done_s;
      b_err_r     <= b_err_s;
      cmp_valid_r <= cmp_valid_s;
      cmp_exp_r   <= cmp_exp_s;
    end
  end

  assign csn     = csn_r;
  assign wen     = wen_r;
  assign wr_data = wr_data_r;
  assign wr_addr = wr_addr_r;
  assign b_done  = b_done_r;
  assign b_err   = b_err_r;

endmodule

// File: tb/tb_sram_bist.sv
// Directed bench for sram_bist with a behavioural SRAM and selectable read faults.
module tb_sram_bist;

  logic       clock;
  logic       n_reset;
  logic       bist_en;
  logic [9:0] rd_data;
  logic       csn;
  logic       wen;
  logic [9:0] wr_data;
  logic [7:0] wr_addr;
  logic       b_done;
  logic       b_err;

  logic [9:0] mem [0:255];
  logic [9:0] q;
  int         fault_mode;
  int         edge_n;
  int         n_tests;
  int         n_fail;

  sram_bist dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bist_en (bist_en),
    .rd_data (rd_data),
    .csn     (csn),
    .wen     (wen),
    .wr_data (wr_data),
    .wr_addr (wr_addr),
    .b_done  (b_done),
    .b_err   (b_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural SRAM; fault mode 2 corrupts address 0x80 only while it holds 2AA.
  always @(posedge clock) begin
    if (!csn) begin
      if (!wen) begin
        mem[wr_addr] <= wr_data;
      end else if ((fault_mode == 2) && (wr_addr == 8'h80) && (mem[wr_addr] == 10'h2AA)) begin
        q <= 10'h2AB;
      end else begin
        q <= mem[wr_addr];
      end
    end
  end

  assign rd_data = (fault_mode == 1) ? {q[9:1], 1'b0} : q;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (edge %0d): got %h expected %h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    edge_n++;
  endtask

  // Raise bist_en so the next edge is E0; edge_n then counts edges past E0.
  task automatic start_run();
    bist_en = 1'b1;
    tick();
    edge_n = 0;
  endtask

  task automatic run_until(input int target);
    while (edge_n < target) tick();
  endtask

  // Expected outputs after edge En of a fault-free run, straight from the edge table.
  task automatic check_table();
    int k, m;
    logic [9:0] pat;
    k = edge_n / 513;
    m = edge_n % 513;
    pat = (k == 0) ? 10'h3FF : (k == 1) ? 10'h000 : 10'h2AA;
    if (m < 256) begin
      check_eq("write_phase", {csn, wen, wr_addr, wr_data, b_done, b_err},
               {1'b0, 1'b0, 8'(m), pat, 1'b0, 1'b0});
    end else if (m < 512) begin
      check_eq("read_phase", {csn, wen, wr_addr, wr_data, b_done, b_err},
               {1'b0, 1'b1, 8'(m - 256), pat, 1'b0, 1'b0});
    end else begin
      check_eq("drain_phase", {csn, wen, b_done, b_err}, 4'b1100);
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    edge_n     = 0;
    fault_mode = 0;
    q          = 10'd0;
    n_reset    = 1'b0;
    bist_en    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset_outputs", {csn, wen, wr_addr, wr_data, b_done, b_err}, {1'b1, 1'b1, 8'd0, 10'd0, 1'b0, 1'b0});
    n_reset = 1'b1;
    repeat (20) tick();
    check_eq("idle_hold", {csn, wen, wr_addr, wr_data, b_done, b_err}, {1'b1, 1'b1, 8'd0, 10'd0, 1'b0, 1'b0});

    // Fault-free run, checked edge by edge against the table.
    start_run();
    check_table();
    for (int n = 1; n <= 1538; n++) begin
      tick();
      check_table();
    end
    tick();
    check_eq("clean_done", {b_done, b_err, csn, wen}, 4'b1011);
    repeat (5) tick();
    check_eq("done_hold", {b_done, b_err}, 2'b10);

    // Completed run, then drop bist_en.
    bist_en = 1'b0;
    tick();
    check_eq("done_exit", {b_done, b_err, csn, wen}, 4'b0011);

    // rd_data[0] stuck at 0: first compare at E258 fails.
    fault_mode = 1;
    start_run();
    check_eq("stuck_start_err", b_err, 1'b0);
    run_until(257);
    check_eq("stuck_before_e258", b_err, 1'b0);
    tick();
    check_eq("stuck_at_e258", b_err, 1'b1);
    run_until(1538);
    check_eq("stuck_not_done", b_done, 1'b0);
    tick();
    check_eq("stuck_done", {b_done, b_err}, 2'b11);
    bist_en = 1'b0;
    tick();
    check_eq("stuck_exit_held", {b_done, b_err}, 2'b01);
    repeat (5) tick();
    check_eq("stuck_idle_held", {b_done, b_err}, 2'b01);

    // Single corrupt word at 0x80 during the 2AA read; restart must clear b_err.
    fault_mode = 2;
    start_run();
    check_eq("restart_clears_err", b_err, 1'b0);
    run_until(1411);
    check_eq("addr80_before_e1412", b_err, 1'b0);
    tick();
    check_eq("addr80_at_e1412", b_err, 1'b1);
    run_until(1539);
    check_eq("addr80_done", {b_done, b_err}, 2'b11);
    bist_en = 1'b0;
    tick();

    // Abort in the read phase with a faulty SRAM, then restart clean.
    fault_mode = 1;
    start_run();
    run_until(300);
    check_eq("abort_pre_err", {b_err, csn, wen}, 3'b101);
    bist_en = 1'b0;
    tick();
    check_eq("abort_idle", {csn, wen, wr_addr, b_done, b_err}, {1'b1, 1'b1, 8'd0, 1'b0, 1'b1});
    repeat (5) tick();
    check_eq("abort_hold", {csn, wen, b_done, b_err}, 4'b1101);
    fault_mode = 0;
    start_run();
    check_eq("abort_restart", {csn, wen, wr_addr, wr_data, b_err}, {1'b0, 1'b0, 8'd0, 10'h3FF, 1'b0});
    tick();
    check_eq("abort_restart_e1", {wr_addr, wr_data}, {8'd1, 10'h3FF});
    run_until(1539);
    check_eq("abort_rerun_done", {b_done, b_err}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
